dsp_frame_loader: RTL and testbench

//  Producer side of the DSPCore sample interface (clk, reset, start, inputs[8]).

---
 rtl/dsp_frame_loader.sv | 125 ++++++++++++
 tb/tb_dsp_frame_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : dsp_frame_loader
// Description : Producer side of the DSPCore sample interface. Gathers
//               CHANNELS words from a valid/ready stream into a shadow buffer
//               and, on each sample_strobe, copies the whole buffer into the
//               live `inputs` array while pulsing `start` for one cycle.
//               Because of this double buffering, `inputs` stays stable while
//               the core processes a sample.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               s_data/s_valid/s_last/s_ready - inbound word stream
//               sample_strobe     - one-cycle sample-rate tick
//               start             - one-cycle "new frame" pulse to DSPCore
//               inputs[CHANNELS]  - live frame presented to DSPCore
//               underrun_cnt      - strobes with no complete frame (saturating)
//               framing_cnt       - frames dropped for s_last misalignment
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_frame_loader #(
    parameter int WIDTH    = 36,
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             sample_strobe,
    output logic             start,
    output logic [WIDTH-1:0] inputs [CHANNELS],
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] framing_cnt
);

    localparam int c_IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(CHANNELS - 1);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_FULL = 1'b1;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_start;
    logic [CNT_W-1:0]   r_underrun_cnt;
    logic [CNT_W-1:0]   r_framing_cnt;
    logic [WIDTH-1:0]   r_shadow [CHANNELS];
    logic [WIDTH-1:0]   r_inputs [CHANNELS];

    logic w_accept;
    logic w_at_last;
    logic w_framing_err;

    // Ready depends on the state alone, so upstream never sees a comb path
    // from its own valid back to ready.
    assign s_ready       = (r_state == c_ST_FILL);
    assign w_accept      = s_ready && s_valid;
    assign w_at_last     = (r_idx == c_LAST_IDX);
    // Misaligned s_last: either too early, or missing on the final channel.
    assign w_framing_err = w_accept && (w_at_last ? !s_last : s_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_FILL;
            r_idx          <= '0;
            r_start        <= 1'b0;
            r_underrun_cnt <= '0;
            r_framing_cnt  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_shadow[k] <= '0;
                r_inputs[k] <= '0;
            end
        end else begin
            // Every strobe starts the core: a fresh frame if one is ready,
            // otherwise the previous frame is processed again.
            r_start <= sample_strobe;

            if (w_framing_err && (r_framing_cnt != {CNT_W{1'b1}})) begin
                r_framing_cnt <= r_framing_cnt + 1'b1;
            end

            case (r_state)
                c_ST_FILL: begin
                    // A strobe while still filling counts as an underrun, even
                    // when the final word lands this same cycle; that frame
                    // then waits for the next strobe.
                    if (sample_strobe && (r_underrun_cnt != {CNT_W{1'b1}})) begin
                        r_underrun_cnt <= r_underrun_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        // A final-channel word without s_last is dropped.
                        if (!(w_at_last && !s_last)) begin
                            r_shadow[r_idx] <= s_data;
                        end
                        if (w_at_last || s_last) begin
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                        if (w_at_last && s_last) begin
                            r_state <= c_ST_FULL;
                        end
                    end
                end
                c_ST_FULL: begin
                    if (sample_strobe) begin
                        for (int k = 0; k < CHANNELS; k++) begin
                            r_inputs[k] <= r_shadow[k];
                        end
                        r_state <= c_ST_FILL;
                    end
                end
                default: r_state <= c_ST_FILL;
            endcase
        end
    end

    assign start        = r_start;
    assign inputs       = r_inputs;
    assign underrun_cnt = r_underrun_cnt;
    assign framing_cnt  = r_framing_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dsp_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_frame_loader
// Description : Self-checking bench for dsp_frame_loader. A frame-level
//               reference model predicts each commit; expected results are
//               queued when a strobe is driven and matched when start fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_frame_loader;

    localparam int WIDTH    = 36;
    localparam int CHANNELS = 8;
    localparam int CNT_W    = 4;
    localparam int c_CMAX   = (1 << CNT_W) - 1;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] frame_t;
    typedef struct {
        longint cyc;
        frame_t frame;
        int     und;
        int     fram;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic             sample_strobe;
    logic             start;
    logic [WIDTH-1:0] inputs [CHANNELS];
    logic [CNT_W-1:0] underrun_cnt;
    logic [CNT_W-1:0] framing_cnt;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // Reference model state: partial frame as a word list, a pending full
    // frame, the frame the core currently sees, and the two counters.
    logic [WIDTH-1:0] m_part [$];
    frame_t           m_shadow;
    frame_t           m_live;
    bit               m_full;
    int               m_und;
    int               m_fram;
    exp_t             sb [$];

    dsp_frame_loader #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .sample_strobe(sample_strobe),
        .start        (start),
        .inputs       (inputs),
        .underrun_cnt (underrun_cnt),
        .framing_cnt  (framing_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t pack_inputs();
        frame_t f;
        for (int k = 0; k < CHANNELS; k++) f[k] = inputs[k];
        return f;
    endfunction

    // Monitor: handshake level every cycle, and each start pulse against the
    // oldest queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset !== 1'b1) begin
            chk("s_ready", longint'(s_ready), longint'(!m_full));
            if (start === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("start_spurious", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    checks++;
                    if (pack_inputs() !== e.frame) begin
                        errors++;
                        $display("FAIL inputs: got %h expected %h", pack_inputs(), e.frame);
                    end
                    chk("underrun_cnt", longint'(underrun_cnt), longint'(e.und));
                    chk("framing_cnt", longint'(framing_cnt), longint'(e.fram));
                end
            end else if (start !== 1'b0) begin
                chk("start_known", 0, 1);
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                chk("start_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // One cycle of stimulus; the model advances by the same cycle.
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit stb);
        bit   pre_full;
        exp_t e;
        @(negedge clk);
        reset         = 1'b0;
        s_valid       = v;
        s_data        = d;
        s_last        = l;
        sample_strobe = stb;
        pre_full      = m_full;
        if (stb) begin
            if (pre_full) begin
                m_live = m_shadow;
                m_full = 1'b0;
            end else if (m_und < c_CMAX) begin
                m_und++;
            end
        end
        if (v && !pre_full) begin
            m_part.push_back(d);
            if (l || m_part.size() == CHANNELS) begin
                if (l && m_part.size() == CHANNELS) begin
                    for (int k = 0; k < CHANNELS; k++) m_shadow[k] = m_part[k];
                    m_full = 1'b1;
                end else if (m_fram < c_CMAX) begin
                    m_fram++;
                end
                m_part.delete();
            end
        end
        if (stb) begin
            e.cyc   = cyc + 1;
            e.frame = m_live;
            e.und   = m_und;
            e.fram  = m_fram;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] base);
        for (int k = 0; k < CHANNELS; k++)
            drive(1, base + WIDTH'(k), k == CHANNELS - 1, 0);
    endtask

    task automatic do_reset();
        idle(1);
        @(negedge clk);
        reset = 1'b1; s_valid = 0; s_last = 0; sample_strobe = 0; s_data = '0;
        m_part.delete(); m_shadow = '0; m_live = '0; m_full = 0; m_und = 0; m_fram = 0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("rst_s_ready", longint'(s_ready), 1);
        chk("rst_start", longint'(start), 0);
        chk("rst_underrun", longint'(underrun_cnt), 0);
        chk("rst_framing", longint'(framing_cnt), 0);
        checks++;
        if (pack_inputs() !== '0) begin
            errors++;
            $display("FAIL rst_inputs: got %h expected 0", pack_inputs());
        end
    endtask

    initial begin
        reset = 1'b1; s_valid = 0; s_last = 0; sample_strobe = 0; s_data = '0;

        // 1: basic frame and commit
        do_reset();
        for (int k = 0; k < CHANNELS; k++)
            drive(1, WIDTH'(k + 1) << 10, k == CHANNELS - 1, 0);
        idle(1);
        chk("t1_backpressure", longint'(s_ready), 0);
        drive(0, '0, 0, 1);
        idle(1);
        chk("t1_in0", longint'(inputs[0]), longint'(1) << 10);
        chk("t1_in7", longint'(inputs[7]), longint'(8) << 10);

        // 2: strobe with nothing loaded
        do_reset();
        drive(0, '0, 0, 1);
        idle(1);
        chk("t2_underrun", longint'(underrun_cnt), 1);
        chk("t2_in0", longint'(inputs[0]), 0);

        // 3: early s_last, then a clean frame
        do_reset();
        for (int k = 0; k < 3; k++) drive(1, 36'h0AA + WIDTH'(k), k == 2, 0);
        send_frame(36'h100);
        drive(0, '0, 0, 1);
        idle(1);
        chk("t3_framing", longint'(framing_cnt), 1);
        chk("t3_in0", longint'(inputs[0]), 36'h100);

        // 4: backpressure while full
        do_reset();
        send_frame(36'h200);
        for (int i = 0; i < 20; i++) drive(1, WIDTH'($urandom), $urandom_range(0, 1), 0);
        drive(0, '0, 0, 1);
        send_frame(36'h300);
        drive(0, '0, 0, 1);
        idle(1);
        chk("t4_in0", longint'(inputs[0]), 36'h300);

        // 5: last word coincides with strobe
        do_reset();
        for (int k = 0; k < CHANNELS - 1; k++) drive(1, 36'h400 + WIDTH'(k), 0, 0);
        drive(1, 36'h407, 1, 1);
        idle(1);
        chk("t5_underrun", longint'(underrun_cnt), 1);
        chk("t5_in0", longint'(inputs[0]), 0);
        drive(0, '0, 0, 1);
        idle(1);
        chk("t5_commit", longint'(inputs[7]), 36'h407);

        // 6: reset mid-frame
        do_reset();
        for (int k = 0; k < 4; k++) drive(1, 36'h500 + WIDTH'(k), 0, 0);
        do_reset();
        send_frame(36'h600);
        drive(0, '0, 0, 1);
        idle(1);
        chk("t6_in3", longint'(inputs[3]), 36'h603);
        chk("t6_underrun", longint'(underrun_cnt), 0);
        chk("t6_framing", longint'(framing_cnt), 0);

        // Random traffic, long enough to saturate both counters
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit v, l, stb;
            v   = ($urandom_range(0, 3) != 0);
            l   = (m_part.size() == CHANNELS - 1) ^ ($urandom_range(0, 15) == 0);
            stb = ($urandom_range(0, 11) == 0);
            drive(v, {WIDTH'($urandom), 4'($urandom)}, l, stb);
        end
        idle(3);
        chk("sat_underrun", longint'(underrun_cnt), longint'(m_und));
        chk("sat_framing", longint'(framing_cnt), longint'(m_fram));
        chk("sb_drained", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
